rom_seq_ctrl: RTL and testbench
===============================

ROM_SEQ_CTRL -- requirements
Module: rom_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of ROM words; legal range 2..2**ADDR_W.
REQ-003 SHALL have parameter CNT_MAX, default 24'd9_999_999, step period minus one, in clocks; CNT_MAX=99 gives a 100-clock step.
REQ-004 SHALL have parameter NUM_KEY, default 2, number of key channels; legal range 1..8.
REQ-005 SHALL have parameter JUMP_ADDR, default {8'd199, 8'd99}, packed NUM_KEY*ADDR_W jump targets; slice i is the target for key i.
REQ-006 SHALL have parameter FILTER_MAX, default 20'd999_999, debounce stable time minus one; used only with KEY_DEBOUNCE_EN.
REQ-007 sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-008 sys_rst_n  input  1  asynchronous active-low reset.
REQ-009 key  input  NUM_KEY  active-high key requests, one bit per channel.
REQ-010 dir  input  1  step direction; 1 = increment, 0 = decrement.
REQ-011 addr  output  ADDR_W  registered ROM read address.
REQ-012 hold  output  1  registered; 1 while in HOLD.
REQ-013 hold_sel  output  3  registered index of the key that owns HOLD; 0 when not holding.

Function
REQ-014 SHALL implement a two-state FSM: RUN and HOLD.
REQ-015 SHALL run a step counter cnt in both states: 0..CNT_MAX, then wrap to 0; cnt==CNT_MAX is a step tick.
REQ-016 On a step tick in RUN, addr SHALL advance by one in the direction of dir, sampled on the tick cycle.
REQ-017 Increment SHALL wrap from DEPTH-1 to 0; decrement SHALL wrap from 0 to DEPTH-1.
REQ-018 In HOLD, addr SHALL NOT change on step ticks.
REQ-019 A key event is a single-cycle high on the per-channel request after optional debounce (REQ-028); one event per press.
REQ-020 Event i in RUN: next cycle, state=HOLD, addr=JUMP_ADDR[i], hold=1, hold_sel=i, cnt=0.
REQ-021 Event i in HOLD with hold_sel==i: next cycle, state=RUN, hold=0, hold_sel=0, cnt=0; addr keeps its value and stepping resumes from it.
REQ-022 Event j in HOLD with hold_sel!=j: next cycle, addr=JUMP_ADDR[j], hold_sel=j, cnt=0; state stays HOLD.
REQ-023 Simultaneous events: the lowest index wins and all others in that cycle are discarded.
REQ-024 A key event coinciding with a step tick: the key action SHALL win and the step SHALL be dropped.
REQ-025 Key-to-output latency SHALL be exactly one clock from the event cycle.

Reset
REQ-026 Assertion of sys_rst_n low SHALL immediately, at any time including mid-step or mid-debounce, force:
- addr=0, hold=0, hold_sel=0
- state=RUN, cnt=0
- all debounce counters and edge registers cleared.
REQ-027 After release, the first step tick SHALL occur on the CNT_MAX+1th rising edge.

Configuration
REQ-028 Macro KEY_DEBOUNCE_EN controls key filtering.
- Defined: each key bit passes through a filter that emits one event after the key has been stable high for FILTER_MAX+1 clocks; release re-arms it, and bounces restart the count.
- Undefined: key is treated as clean, and a rising edge of key[i] (previous sample 0, current 1) is the event, with no filter logic.

Structure
REQ-029 A shared package rom_seq_pkg SHALL hold the FSM state typedef (RUN, HOLD) and the default CNT_MAX/FILTER_MAX constants.
REQ-030 The per-channel filter SHALL be sub-module key_filter, instantiated NUM_KEY times under KEY_DEBOUNCE_EN; all else is in rom_seq_ctrl.

Verification (defaults, CNT_MAX=99, macro undefined)
REQ-031 Release reset, dir=1, run 300 clocks -> addr steps 0,1,2 at 100-clock intervals; hold=0.
REQ-032 key[0] 1-clock pulse at addr=5 -> next cycle addr=99, hold=1, hold_sel=0; addr stays 99 for 1000 clocks.
REQ-033 In HOLD on key0, pulse key[1] -> addr=199, hold_sel=1; then pulse key[1] -> hold=0, and 100 clocks later addr=200.
REQ-034 dir=0 from reset -> first step gives addr=255; dir=1 at addr=255 -> next step gives addr=0.
REQ-035 key=2'b11 in a single cycle -> addr=99, hold_sel=0; a key pulse on the step-tick cycle -> jump taken, no step.
REQ-036 Reset pulled low mid-HOLD and mid-count -> addr=0, hold=0 asynchronously. With KEY_DEBOUNCE_EN and FILTER_MAX=9: a 5-clock key high gives no event, and a 10-clock key high gives exactly one event.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// Shared types and default timing constants for the ROM address sequencer.
package rom_seq_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int unsigned CNT_MAX_DEF    = 24'd9_999_999;
    localparam int unsigned FILTER_MAX_DEF = 20'd999_999;

endpackage

// File: rtl/key_filter.sv
// Single-channel key debouncer: one event once the key has been stable high for
// FILTER_MAX+1 clocks; a release re-arms it, and any low sample restarts the count.
module key_filter
    import rom_seq_pkg::*;
#(
    parameter int unsigned FILTER_MAX = FILTER_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_event
);

    localparam int unsigned FW = (FILTER_MAX > 0) ? $clog2(FILTER_MAX + 1) : 1;

    logic [FW-1:0] stable_cnt;
    logic          fired;
    logic          at_max;

    assign at_max    = (stable_cnt == FW'(FILTER_MAX));
    assign key_event = key_in && !fired && at_max;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stable_cnt <= '0;
            fired      <= 1'b0;
        end else if (!key_in) begin
            stable_cnt <= '0;
            fired      <= 1'b0;
        end else if (!fired) begin
            if (at_max) begin
                fired <= 1'b1;
            end else begin
                stable_cnt <= stable_cnt + FW'(1);
            end
        end
    end

endmodule

// File: rtl/rom_seq_ctrl.sv
// ROM read-address sequencer: steps addr every CNT_MAX+1 clocks, key events jump
// to per-key targets and hold there. Define KEY_DEBOUNCE_EN to debounce the keys.
module rom_seq_ctrl
    import rom_seq_pkg::*;
#(
    parameter int unsigned               ADDR_W     = 8,
    parameter int unsigned               DEPTH      = 256,
    parameter int unsigned               CNT_MAX    = CNT_MAX_DEF,
    parameter int unsigned               NUM_KEY    = 2,
    parameter logic [NUM_KEY*ADDR_W-1:0] JUMP_ADDR  = {8'd199, 8'd99},
    parameter int unsigned               FILTER_MAX = FILTER_MAX_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [NUM_KEY-1:0] key,
    input  logic               dir,
    output logic [ADDR_W-1:0]  addr,
    output logic               hold,
    output logic [2:0]         hold_sel
);

    localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               tick;
    logic [NUM_KEY-1:0] key_evt;
    logic               key_hit;
    logic [2:0]         key_idx;
    logic [ADDR_W-1:0]  jump_tgt, addr_step, addr_nxt;
    logic [2:0]         hold_sel_nxt;

`ifdef KEY_DEBOUNCE_EN
    for (genvar g = 0; g < NUM_KEY; g++) begin : g_filter
        key_filter #(.FILTER_MAX(FILTER_MAX)) u_key_filter (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_in    (key[g]),
            .key_event (key_evt[g])
        );
    end
`else
    logic [NUM_KEY-1:0] key_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) key_q <= '0;
        else            key_q <= key;
    end

    assign key_evt = key & ~key_q;
`endif

    assign tick = (cnt == CNT_W'(CNT_MAX));
    assign hold = (state == HOLD);

    // Scan downwards so the lowest-indexed simultaneous event is the one kept.
    always_comb begin
        key_hit  = 1'b0;
        key_idx  = '0;
        jump_tgt = '0;
        for (int i = NUM_KEY - 1; i >= 0; i--) begin
            if (key_evt[i]) begin
                key_hit  = 1'b1;
                key_idx  = 3'(i);
                jump_tgt = JUMP_ADDR[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        if (dir) addr_step = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
        else     addr_step = (addr == '0) ? ADDR_W'(DEPTH - 1) : addr - ADDR_W'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= RUN;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (key_hit) begin
            if (state == RUN)              state_nxt = HOLD;
            else if (key_idx == hold_sel)  state_nxt = RUN;
        end
    end

    // A key event always restarts the step period, so a coinciding tick is lost.
    always_comb begin
        addr_nxt     = addr;
        hold_sel_nxt = hold_sel;
        cnt_nxt      = tick ? '0 : cnt + CNT_W'(1);
        if (key_hit) begin
            cnt_nxt = '0;
            if (state == RUN || key_idx != hold_sel) begin
                addr_nxt     = jump_tgt;
                hold_sel_nxt = key_idx;
            end else begin
                hold_sel_nxt = '0;
            end
        end else if (tick && state == RUN) begin
            addr_nxt = addr_step;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr     <= '0;
            hold_sel <= '0;
            cnt      <= '0;
        end else begin
            addr     <= addr_nxt;
            hold_sel <= hold_sel_nxt;
            cnt      <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Scoreboard bench for rom_seq_ctrl: a behavioural model predicts addr/hold/hold_sel
// for every clock; a monitor compares the DUT against the predictions one edge later.
module tb_rom_seq_ctrl;

    localparam int ADDR_W     = 8;
    localparam int DEPTH      = 256;
    localparam int CNT_MAX    = 99;
    localparam int NUM_KEY    = 2;
    localparam int FILTER_MAX = 9;

    typedef struct {
        int addr;
        bit hold;
        int sel;
    } exp_t;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic [NUM_KEY-1:0] key = '0;
    logic               dir = 1'b1;
    logic [ADDR_W-1:0]  addr;
    logic               hold;
    logic [2:0]         hold_sel;

    exp_t exp_q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    int   jump_tab[NUM_KEY] = '{99, 199};
    int   m_addr = 0;
    int   m_phase = 0;
    int   m_sel = 0;
    bit   m_hold = 1'b0;
    logic [NUM_KEY-1:0] m_prev = '0;
    int   m_stab[NUM_KEY] = '{0, 0};
    bit   m_fired[NUM_KEY] = '{1'b0, 1'b0};

    rom_seq_ctrl #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .CNT_MAX    (CNT_MAX),
        .NUM_KEY    (NUM_KEY),
        .JUMP_ADDR  ({8'd199, 8'd99}),
        .FILTER_MAX (FILTER_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key),
        .dir       (dir),
        .addr      (addr),
        .hold      (hold),
        .hold_sel  (hold_sel)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input exp_t e);
        chk_cnt++;
        if (int'(addr) == e.addr && hold == e.hold && int'(hold_sel) == e.sel) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s @%0t: got addr=%0d hold=%0d sel=%0d, expected addr=%0d hold=%0d sel=%0d",
                     name, $time, addr, hold, hold_sel, e.addr, e.hold, e.sel);
        end
    endtask

    function automatic void modelReset();
        m_addr  = 0;
        m_phase = 0;
        m_sel   = 0;
        m_hold  = 1'b0;
        m_prev  = '0;
        for (int i = 0; i < NUM_KEY; i++) begin
            m_stab[i]  = 0;
            m_fired[i] = 1'b0;
        end
    endfunction

    // Drive one clock of inputs, predict the state after the next edge, then wait.
    task automatic applyStimulus(input logic [NUM_KEY-1:0] k, input logic d);
        logic [NUM_KEY-1:0] ev;
        int   win;
        exp_t e;
        key = k;
        dir = d;
`ifdef KEY_DEBOUNCE_EN
        for (int i = 0; i < NUM_KEY; i++) begin
            ev[i] = k[i] && !m_fired[i] && (m_stab[i] == FILTER_MAX);
            if (!k[i]) begin
                m_stab[i]  = 0;
                m_fired[i] = 1'b0;
            end else if (!m_fired[i]) begin
                if (m_stab[i] == FILTER_MAX) m_fired[i] = 1'b1;
                else                         m_stab[i]++;
            end
        end
`else
        ev = k & ~m_prev;
`endif
        m_prev = k;
        win = -1;
        for (int i = NUM_KEY - 1; i >= 0; i--) if (ev[i]) win = i;
        if (win >= 0) begin
            m_phase = 0;
            if (!m_hold) begin
                m_hold = 1'b1;
                m_sel  = win;
                m_addr = jump_tab[win];
            end else if (m_sel == win) begin
                m_hold = 1'b0;
                m_sel  = 0;
            end else begin
                m_sel  = win;
                m_addr = jump_tab[win];
            end
        end else begin
            if (m_phase == CNT_MAX && !m_hold)
                m_addr = d ? (m_addr + 1) % DEPTH : (m_addr + DEPTH - 1) % DEPTH;
            m_phase = (m_phase == CNT_MAX) ? 0 : m_phase + 1;
        end
        e.addr = m_addr;
        e.hold = m_hold;
        e.sel  = m_sel;
        exp_q.push_back(e);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) applyStimulus('0, d);
    endtask

    // Reset is asserted just after the monitor has sampled, away from any edge.
    task automatic doReset(input int cycles);
        exp_t z;
        z.addr = 0;
        z.hold = 1'b0;
        z.sel  = 0;
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        key = '0;
        #1;
        checkOutput("async_reset", z);
        repeat (cycles) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        modelReset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("scoreboard", e);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [NUM_KEY-1:0] k;
        logic d;
        exp_t z;
        z.addr = 0;
        z.hold = 1'b0;
        z.sel  = 0;

        #3;
        checkOutput("reset_state", z);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        modelReset();

        // Free run upward, then jump on key0 at addr 5 and hold.
        idle(300, 1'b1);
        for (int n = 0; n < 1000 && m_addr != 5; n++) applyStimulus('0, 1'b1);
        applyStimulus(2'b01, 1'b1);
        idle(1000, 1'b1);

        // Switch hold owner to key1, then release and resume stepping.
        applyStimulus(2'b10, 1'b1);
        idle(20, 1'b1);
        applyStimulus(2'b10, 1'b1);
        idle(150, 1'b1);

        // Decrement wraps below zero, increment wraps above DEPTH-1.
        doReset(2);
        idle(100, 1'b0);
        idle(100, 1'b1);

        // Simultaneous keys, then key pulses landing exactly on step ticks.
        applyStimulus(2'b11, 1'b1);
        idle(30, 1'b1);
        for (int n = 0; n < 200 && m_phase != CNT_MAX; n++) applyStimulus('0, 1'b1);
        applyStimulus(2'b01, 1'b1);
        idle(40, 1'b1);
        for (int n = 0; n < 200 && m_phase != CNT_MAX; n++) applyStimulus('0, 1'b1);
        applyStimulus(2'b10, 1'b1);
        idle(120, 1'b1);

        // Reset in the middle of a hold and a partial step period.
        idle(37, 1'b1);
        doReset(3);
        idle(150, 1'b1);

`ifdef KEY_DEBOUNCE_EN
        for (int i = 0; i < 5; i++)  applyStimulus(2'b01, 1'b1);
        idle(10, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(2'b01, 1'b1);
        idle(20, 1'b1);
`endif

        // Randomised keys and direction against the model.
        k = '0;
        d = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)  k = NUM_KEY'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) d = ~d;
            applyStimulus(k, d);
        end
        idle(5, d);

        @(posedge sys_clk);
        #2;
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("[TB] FAIL drain: got %0d pending predictions, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
